instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit that reads the `PC` produced by the `programcounter` block. It issues one instruction-memory read per `PC` value over a req/ack handshake and buffers fetched words with their addresses in a small FIFO for the decoder. It holds the PC through `pc_stall` while a fetch is in flight and discards in-flight and buffered instructions when a jump is taken.

## Interface
Parameters:
- `DEPTH`, default 4: instruction FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PC`  in  32  current program counter from `programcounter`.
- `flush`  in  1  jump taken this cycle; asserted in the same cycle as `mux_command`=1 to the PC.
- `pc_stall`  out  1  high means the PC must hold its value this cycle.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  read address; stable while `imem_req`=1.
- `imem_ack`  in  1  read data valid; one-cycle pulse.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `instr_valid`  out  1  FIFO head is valid.
- `instr`  out  32  FIFO head instruction.
- `instr_pc`  out  32  address of the FIFO head instruction.
- `instr_ready`  in  1  consumer accepts the head.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding; response is kept.
  - DROP: request outstanding; response will be discarded.
- IDLE to REQ when `count` < `DEPTH` and `flush`=0. On that edge `imem_addr` is loaded with `PC`.
- IDLE otherwise stays in IDLE. `imem_ack` is ignored in IDLE.
- REQ with `imem_ack`=1 and `flush`=0: push {`imem_addr`, `imem_rdata`} into the FIFO, then go to IDLE.
- REQ with `flush`=1 and `imem_ack`=1: discard the response and go to IDLE.
- REQ with `flush`=1 and `imem_ack`=0: go to DROP.
- DROP with `imem_ack`=1: discard the response and go to IDLE. `flush` in DROP has no further effect.
- `imem_req` is 1 in REQ and DROP, 0 in IDLE. The memory sees one continuous request until ack and must not be retracted.
- `pc_stall` is 0 only in REQ when `imem_ack`=1 and `flush`=0; otherwise it is 1. The PC therefore advances exactly once per kept fetch.
  - On a flush, the PC loads the jump target regardless of `pc_stall`. The jump mux has priority in `programcounter`.
- FIFO:
  - A transfer happens when `instr_valid`=1 and `instr_ready`=1.
  - Pop and push in the same cycle: `count` is unchanged.
  - A push always has room, because issue requires `count` < `DEPTH` and only one request is outstanding.
- `instr_valid` = (`count` != 0) and `flush`=0. No transfer occurs in a flush cycle.
- `flush`: at the edge, `count`, read pointer and write pointer all go to 0. The flush overrides any push or pop in that cycle.
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. `count` is log2(`DEPTH`)+1 bits.

## Timing
- Reset values:
  - state IDLE; `count` 0; pointers 0.
  - `imem_req` 0; `imem_addr` 0.
  - `instr_valid` 0; `instr` 0; `instr_pc` 0 (empty head reads as 0).
  - `pc_stall` 1.
- Reset asserted mid-request returns the FSM to IDLE. A late `imem_ack` after reset is ignored.
- Minimum fetch latency:
  - cycle 0: IDLE, `PC` sampled.
  - cycle 1: `imem_req`=1 with `imem_ack`=1.
  - cycle 2: `instr_valid`=1.
- Peak throughput is one fetch per 2 cycles.
- Each memory wait cycle adds one cycle of latency. `pc_stall` stays 1 for the whole wait.
- After a flush, the first fetch of the jump target issues on the cycle after the FSM reaches IDLE.

## Test plan
- Reset, PC=0, ack returned in the same cycle as req, `instr_ready`=1:
  - `imem_addr` sequence 0, 4, 8.
  - `instr_pc` sequence 0, 4, 8 with the matching `imem_rdata`.
  - `pc_stall` low one cycle in every two.
- `instr_ready`=0, `DEPTH`=4: four fetches (PC 0, 4, 8, 12), then `imem_req` stays 0 and `pc_stall` stays 1. One pop, then the fetch of 16 issues.
- Memory waits 3 cycles before ack: `imem_req` is high for 3 cycles with `imem_addr` stable; `pc_stall`=1 throughout; `instr_valid` rises 1 cycle after the ack.
- FIFO holds 8 and 12, a request for 16 is outstanding, `flush` is asserted with PC jumping to 20:
  - FIFO empties; `instr_valid`=0 in the flush cycle.
  - The ack for 16 arrives 2 cycles later and is discarded.
  - Next `imem_addr`=20; next `instr_pc`=20.
- Flush in the same cycle as the ack: the response is dropped, no push, FSM returns to IDLE; the next fetch address is the jump target.
- `reset` asserted while in REQ, with the ack arriving during or after reset: no push; all outputs at reset values; fetching restarts from PC 0.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : One-outstanding-read fetch unit with an address-tagged FIFO.
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    localparam logic [CW-1:0] c_FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic          w_empty;

    assign w_empty = (count_q == '0);
    // A response is kept only when it lands in REQ without a concurrent jump.
    assign w_push  = (state_q == c_REQ) && imem_ack && !flush;
    assign w_pop   = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            c_IDLE: begin
                if ((count_q < c_FULL) && !flush) begin
                    state_d = c_REQ;
                    addr_d  = PC;
                end
            end
            c_REQ: begin
                if (imem_ack) begin
                    state_d = c_IDLE;
                end else if (flush) begin
                    state_d = c_DROP;
                end
            end
            c_DROP: begin
                if (imem_ack) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                count_d = count_q + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                count_d = count_q - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_IDLE;
            addr_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_instr_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]    <= addr_q;
        end
    end

    assign imem_req    = (state_q != c_IDLE);
    assign imem_addr   = addr_q;
    assign pc_stall    = !w_push;
    assign instr_valid = !w_empty && !flush;
    assign instr       = w_empty ? 32'h0 : mem_instr_q[rd_ptr_q];
    assign instr_pc    = w_empty ? 32'h0 : mem_pc_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Self-checking bench: PC model, memory responder, FIFO scoreboard.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic        flush;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] jump_target;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] sb [$];

    typedef struct {
        int          wt;
        logic [31:0] addr;
        logic        cv;
    } vec_t;
    vec_t tbl [5];

    instruction_fetch #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .flush       (flush),
        .pc_stall    (pc_stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    // Program counter: jump has priority over stall.
    always @(posedge clk or posedge reset) begin
        if (reset)          PC <= 32'h0;
        else if (flush)     PC <= jump_target;
        else if (!pc_stall) PC <= PC + 32'd4;
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Consumer side: every transfer must match the oldest expected entry.
    always begin
        @(negedge clk);
        #1;
        if (!reset && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", instr_pc);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("pop_pc", instr_pc, e[63:32]);
                chk("pop_instr", instr, e[31:0]);
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!imem_req) begin
            n_errors++;
            $display("FAIL req_timeout: got imem_req 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic do_fetch(input int wt, input logic [31:0] exp_addr, input logic cv);
        wait_req();
        chk("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < wt; i++) begin
            #1;
            chk("stall_wait", {31'b0, pc_stall}, 32'd1);
            chk("addr_stable", imem_addr, exp_addr);
            chk("req_wait", {31'b0, imem_req}, 32'd1);
            @(negedge clk);
        end
        imem_ack   = 1'b1;
        imem_rdata = data_of(exp_addr);
        sb.push_back({exp_addr, data_of(exp_addr)});
        #1;
        chk("stall_on_ack", {31'b0, pc_stall}, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        if (cv) begin
            #1;
            chk("valid_after_ack", {31'b0, instr_valid}, 32'd1);
        end
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset       = 1'b1;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = rdy;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{0, 32'd0,  1'b1};
        tbl[1] = '{0, 32'd4,  1'b1};
        tbl[2] = '{0, 32'd8,  1'b1};
        tbl[3] = '{3, 32'd12, 1'b1};
        tbl[4] = '{1, 32'd16, 1'b1};

        reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b1; jump_target = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {31'b0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_ipc",   instr_pc,             32'd0);
        chk("rst_stall", {31'b0, pc_stall},    32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back fetches plus memory wait states.
        foreach (tbl[i]) do_fetch(tbl[i].wt, tbl[i].addr, tbl[i].cv);
        repeat (3) @(negedge clk);
        chk("sb_empty_1", 32'(sb.size()), 32'd0);

        // Fill with consumer stalled, then one pop frees a slot.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) do_fetch(0, 32'(i * 4), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("full_noreq",   {31'b0, imem_req}, 32'd0);
            chk("full_stall",   {31'b0, pc_stall}, 32'd1);
        end
        chk("full_head", instr_pc, 32'd0);
        @(negedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        do_fetch(0, 32'd16, 1'b0);
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("sb_empty_2", 32'(sb.size()), 32'd0);

        // Flush with 8,12 buffered and 16 outstanding; ack lands in DROP.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) do_fetch(0, 32'(i * 4), 1'b0);
        @(negedge clk);
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        instr_ready = 1'b0;
        wait_req();
        chk("pre_flush_addr", imem_addr, 32'd16);
        flush = 1'b1;
        jump_target = 32'd20;
        #1;
        chk("flush_valid", {31'b0, instr_valid}, 32'd0);
        chk("flush_stall", {31'b0, pc_stall},    32'd1);
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
        #1;
        chk("drop_req",   {31'b0, imem_req},    32'd1);
        chk("drop_empty", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("drop_stall", {31'b0, pc_stall}, 32'd1);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("drop_nopush", {31'b0, instr_valid}, 32'd0);
        instr_ready = 1'b1;
        do_fetch(0, 32'd20, 1'b1);

        // Flush coincident with ack.
        wait_req();
        chk("pre_flush2_addr", imem_addr, 32'd24);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0024;
        flush = 1'b1;
        jump_target = 32'd100;
        #1;
        chk("flush_ack_stall", {31'b0, pc_stall}, 32'd1);
        @(negedge clk);
        imem_ack = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_ack_idle",   {31'b0, imem_req},    32'd0);
        chk("flush_ack_nopush", {31'b0, instr_valid}, 32'd0);
        do_fetch(0, 32'd100, 1'b1);

        // Reset mid-request with ack during and after reset.
        wait_req();
        chk("pre_rst_addr", imem_addr, 32'd104);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("mrst_req",   {31'b0, imem_req},    32'd0);
        chk("mrst_stall", {31'b0, pc_stall},    32'd1);
        chk("mrst_addr",  imem_addr,            32'd0);
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_instr", instr,                32'd0);
        chk("mrst_ipc",   instr_pc,             32'd0);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0104;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("late_ack_nopush", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        #1;
        chk("late_ack_nopush2", {31'b0, instr_valid}, 32'd0);
        chk("restart_req",      {31'b0, imem_req},    32'd1);
        do_fetch(0, 32'd0, 1'b1);
        do_fetch(0, 32'd4, 1'b1);
        repeat (4) @(negedge clk);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
